snes_controller_emulator: RTL and testbench
===========================================

Name: snes_controller_emulator

Overview:
- Device-side end of the NES/SNES serial pad protocol: responds to the host's Strobe_Latch and Shift_Clock by serialising a button vector onto Data, active-low, one bit per shift.
- Stands in for a physical pad so the console-side reader can be exercised on-board and in simulation.
- Inputs can come from board switches or a test pattern generator.
- All host-side inputs are asynchronous to Clock and are synchronised internally.

Parameters:
- SYNC_STAGES, 2: flip-flop depth of the synchronisers on Strobe_Latch and Shift_Clock; legal values are 2 or more.
- NES_BITS, 8: NES frame length in bits.
- SNES_BITS, 16: SNES frame length in bits.

Ports:
- Clock  input  1  system clock, all state on the rising edge.
- Reset  input  1  asynchronous, active-high reset.
- Strobe_Latch  input  1  host latch; high means parallel load.
- Shift_Clock  input  1  host shift clock; each rising edge advances one bit.
- Mode  input  2  Mode[1]=0 selects NES, Mode[1]=1 selects SNES; Mode[0] is unused.
- Buttons  input  12  active-high pressed: [0]B [1]Y [2]Select [3]Start [4]Up [5]Down [6]Left [7]Right [8]A [9]X [10]L [11]R.
- Data  output  1  serial button stream to host, active-low (0 = pressed), registered.
- Frame_Active  output  1  high from latch fall until the frame completes.
- Frame_Done  output  1  one-Clock pulse when the last frame bit has been shifted past.

Behaviour:
- Reset values: Data=1, Frame_Active=0, Frame_Done=0, state IDLE, bit index 0, shift register all ones.
- Synchronisers: Strobe_Latch and Shift_Clock each pass through SYNC_STAGES flops, followed by one registered edge detector (lat_s, shc_s). Host pin edges therefore take effect SYNC_STAGES+1 Clock cycles later.
- Host timing requirement: each Shift_Clock and Strobe_Latch level must be held at least SYNC_STAGES+2 Clock cycles. Shorter pulses may be missed.
- Load image, 16 bits, index 0 first, values on the wire:
  - NES: ~A, ~B, ~Select, ~Start, ~Up, ~Down, ~Left, ~Right.
  - SNES: ~B, ~Y, ~Select, ~Start, ~Up, ~Down, ~Left, ~Right, ~A, ~X, ~L, ~R, then 1, 1, 1, 1 (unused bits read as not pressed).
- Frame length is latched from Mode[1] at the lat_s falling edge and held for the whole frame.
- States:
  - IDLE: Data=1. A lat_s rising edge goes to LOAD.
  - LOAD (lat_s high): the shift register reloads from Buttons every cycle, so the last value before the fall is used. Data = bit 0 of the image, updated each cycle. Shift_Clock edges are ignored. A lat_s falling edge goes to SHIFT with index 0 and Frame_Active=1.
  - SHIFT: on a shc_s rising edge, shift right, fill with 0, index+1, and Data = the next bit on the following cycle. When index reaches the frame length, go to DONE, Frame_Done=1 for one cycle, Frame_Active=0, Data=0.
  - DONE: Data=0, matching a real pad's post-frame low. Further shift edges are ignored and the index saturates. A lat_s rising edge goes to LOAD.
- A lat_s rising edge in any state goes immediately to LOAD, aborting any frame in progress. Frame_Active drops the same cycle and no Frame_Done is issued.
- A shift edge and a latch rising edge detected in the same cycle: the latch wins and the shift is discarded.
- Buttons are sampled only in LOAD. Changes during SHIFT do not affect the frame in progress.
- Mode changes during SHIFT take effect at the next latch fall.
- Reset asserted mid-frame returns every register to its reset value immediately. The next frame requires a fresh latch.

Test Plan:
1. NES frame, Buttons=12'h010 (Up), Mode=2'b00, latch held 10 cycles, 8 shift pulses of 6 cycles high and 6 low. Required: Data sampled before each shift = 1,1,1,1,0,1,1,1. Frame_Done pulses once, 3 cycles after the 8th edge. Data=0 afterwards.
2. SNES frame, Buttons=12'hF81 (B, Right, A, X, L, R), Mode=2'b10, 16 shifts. Required bit stream 0,1,1,1,1,1,1,0,0,0,0,0,1,1,1,1. Frame_Active is high for exactly the 16-shift window.
3. Latch re-asserted after 3 NES shifts with Buttons changed to 12'h001. Required: no Frame_Done. After the new latch falls, Data=1 at index 0, then 0 at index 1 (B).
4. Shift pulses during latch high, plus 20 extra shifts after DONE. Required: index unchanged during LOAD, Data stays 0 in DONE, and only one Frame_Done.
5. Mode flipped from NES to SNES at shift 4. Required: the frame still ends after 8 bits. The next latch yields a 16-bit frame.
6. Reset pulsed at SNES shift 9. Required: Data=1, Frame_Active=0 asynchronously. A following full frame is bit-exact.

Source files
------------

// File: rtl/snes_controller_emulator.sv
// snes_controller_emulator: device-side NES/SNES pad. Answers the host's latch and
// shift clock by serialising the button vector onto Data, active-low, one bit per shift.
//
// state | meaning
// IDLE  | no frame since reset, Data held high
// LOAD  | latch high, shift register tracks Buttons every cycle
// SHIFT | frame in progress, one bit advanced per synchronised shift rising edge
// DONE  | frame complete, Data held low as a real pad does
module snes_controller_emulator #(
    parameter int SYNC_STAGES = 2,
    parameter int NES_BITS    = 8,
    parameter int SNES_BITS   = 16
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        Strobe_Latch,
    input  logic        Shift_Clock,
    input  logic [1:0]  Mode,
    input  logic [11:0] Buttons,
    output logic        Data,
    output logic        Frame_Active,
    output logic        Frame_Done
);

    localparam int IDX_W = $clog2(SNES_BITS + 1);
    localparam logic [IDX_W-1:0] NES_LEN  = IDX_W'(NES_BITS);
    localparam logic [IDX_W-1:0] SNES_LEN = IDX_W'(SNES_BITS);

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] lat_sync;
    logic [SYNC_STAGES-1:0] shc_sync;
    logic                   lat_s;
    logic                   shc_s;
    logic                   lat_rise;
    logic                   lat_fall;
    logic                   shc_rise;
    logic [SNES_BITS-1:0]   shift_reg;
    logic [SNES_BITS-1:0]   image;
    logic [IDX_W-1:0]       bit_idx;
    logic [IDX_W-1:0]       bit_idx_nxt;
    logic [IDX_W-1:0]       frame_len;
    logic                   unused_mode;

    // Mode[0] carries no meaning for either pad type.
    assign unused_mode = Mode[0];

    // Synchronise host pins into the Clock domain and keep one registered copy for edge detection.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            lat_sync <= '0;
            shc_sync <= '0;
            lat_s    <= 1'b0;
            shc_s    <= 1'b0;
        end else begin
            lat_sync <= {lat_sync[SYNC_STAGES-2:0], Strobe_Latch};
            shc_sync <= {shc_sync[SYNC_STAGES-2:0], Shift_Clock};
            lat_s    <= lat_sync[SYNC_STAGES-1];
            shc_s    <= shc_sync[SYNC_STAGES-1];
        end
    end

    assign lat_rise    = lat_sync[SYNC_STAGES-1] & ~lat_s;
    assign lat_fall    = ~lat_sync[SYNC_STAGES-1] & lat_s;
    assign shc_rise    = shc_sync[SYNC_STAGES-1] & ~shc_s;
    assign bit_idx_nxt = bit_idx + IDX_W'(1);

    // Build the wire image (index 0 first, inverted buttons, unused positions read as released).
    always_comb begin
        image = '1;
        if (Mode[1]) begin
            image[11:0] = ~Buttons;
        end else begin
            image[7:0] = ~{Buttons[7], Buttons[6], Buttons[5], Buttons[4],
                           Buttons[3], Buttons[2], Buttons[0], Buttons[8]};
        end
    end

    // Frame FSM; a latch rising edge overrides everything, including a coincident shift edge.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state        <= IDLE;
            shift_reg    <= '1;
            bit_idx      <= '0;
            frame_len    <= NES_LEN;
            Data         <= 1'b1;
            Frame_Active <= 1'b0;
            Frame_Done   <= 1'b0;
        end else begin
            Frame_Done <= 1'b0;
            if (lat_rise) begin
                state        <= LOAD;
                shift_reg    <= image;
                Data         <= image[0];
                bit_idx      <= '0;
                Frame_Active <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        Data <= 1'b1;
                    end
                    LOAD: begin
                        if (lat_fall) begin
                            state        <= SHIFT;
                            bit_idx      <= '0;
                            Frame_Active <= 1'b1;
                            frame_len    <= Mode[1] ? SNES_LEN : NES_LEN;
                            Data         <= shift_reg[0];
                        end else begin
                            shift_reg <= image;
                            Data      <= image[0];
                        end
                    end
                    SHIFT: begin
                        if (shc_rise) begin
                            shift_reg <= {1'b0, shift_reg[SNES_BITS-1:1]};
                            bit_idx   <= bit_idx_nxt;
                            if (bit_idx_nxt == frame_len) begin
                                state        <= DONE;
                                Frame_Done   <= 1'b1;
                                Frame_Active <= 1'b0;
                                Data         <= 1'b0;
                            end else begin
                                Data <= shift_reg[1];
                            end
                        end
                    end
                    default: begin
                        Data <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_snes_controller_emulator.sv
// Bench for snes_controller_emulator: a scoreboard queue holds the expected wire bits of
// each frame, pushed at latch time and popped as each bit is sampled before its shift.
module tb_snes_controller_emulator;

    logic        Clock;
    logic        Reset;
    logic        Strobe_Latch;
    logic        Shift_Clock;
    logic [1:0]  Mode;
    logic [11:0] Buttons;
    logic        Data;
    logic        Frame_Active;
    logic        Frame_Done;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int done_cnt = 0;
    int act_cnt  = 0;
    int last_done_cyc = 0;
    int last_rise_cyc = 0;
    int fall_cyc      = 0;
    logic exp_q[$];

    snes_controller_emulator dut (
        .Clock        (Clock),
        .Reset        (Reset),
        .Strobe_Latch (Strobe_Latch),
        .Shift_Clock  (Shift_Clock),
        .Mode         (Mode),
        .Buttons      (Buttons),
        .Data         (Data),
        .Frame_Active (Frame_Active),
        .Frame_Done   (Frame_Done)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    always @(posedge Clock) cyc <= cyc + 1;

    always @(negedge Clock) begin
        if (Frame_Done) begin
            done_cnt      = done_cnt + 1;
            last_done_cyc = cyc;
        end
        if (Frame_Active) act_cnt = act_cnt + 1;
    end

    task automatic chk_eq(input string tag, input int got, input int exp);
        checks = checks + 1;
        if (got !== exp) begin
            failures = failures + 1;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Reference wire image, index 0 first.
    function automatic logic [15:0] model_image(input logic [11:0] b, input logic snes);
        int nes_map[8] = '{8, 0, 2, 3, 4, 5, 6, 7};
        logic [15:0] img;
        img = 16'hFFFF;
        for (int i = 0; i < 8; i++) img[i] = snes ? ~b[i] : ~b[nes_map[i]];
        if (snes) for (int i = 8; i < 12; i++) img[i] = ~b[i];
        return img;
    endfunction

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge Clock);
    endtask

    task automatic pulse_shift(input int hi, input int lo);
        Shift_Clock   = 1'b1;
        last_rise_cyc = cyc;
        wait_cyc(hi);
        Shift_Clock = 1'b0;
        wait_cyc(lo);
    endtask

    // Latch with given buttons/mode; optional shift pulses while latch is high.
    task automatic latch_frame(input logic [11:0] b, input logic [1:0] m, input int extra_shc);
        logic [15:0] img;
        int len;
        Buttons      = b;
        Mode         = m;
        Strobe_Latch = 1'b1;
        wait_cyc(6);
        for (int i = 0; i < extra_shc; i++) pulse_shift(5, 5);
        wait_cyc(4);
        Strobe_Latch = 1'b0;
        fall_cyc     = cyc;
        exp_q.delete();
        img = model_image(b, m[1]);
        len = m[1] ? 16 : 8;
        for (int i = 0; i < len; i++) exp_q.push_back(img[i]);
        wait_cyc(6);
    endtask

    task automatic shift_bits(input string tag, input int n);
        logic e;
        for (int i = 0; i < n; i++) begin
            if (exp_q.size() == 0) begin
                chk_eq({tag, "_sb_underflow"}, 0, 1);
            end else begin
                e = exp_q.pop_front();
                chk_eq($sformatf("%s_bit%0d", tag, i), int'(Data), int'(e));
            end
            pulse_shift(6, 6);
        end
    endtask

    int d0, a0;

    initial begin
        Reset = 1'b1; Strobe_Latch = 1'b0; Shift_Clock = 1'b0;
        Mode = 2'b00; Buttons = 12'h000;
        wait_cyc(3);
        chk_eq("rst_data", int'(Data), 1);
        chk_eq("rst_active", int'(Frame_Active), 0);
        chk_eq("rst_done", int'(Frame_Done), 0);
        Reset = 1'b0;
        wait_cyc(3);
        chk_eq("idle_data", int'(Data), 1);

        // 1: NES, Up pressed
        d0 = done_cnt;
        latch_frame(12'h010, 2'b00, 0);
        shift_bits("t1", 8);
        chk_eq("t1_done_cnt", done_cnt - d0, 1);
        chk_eq("t1_done_lat", last_done_cyc - last_rise_cyc, 3);
        chk_eq("t1_data_after", int'(Data), 0);

        // 2: SNES, Frame_Active window
        d0 = done_cnt;
        a0 = act_cnt;
        latch_frame(12'hF81, 2'b10, 0);
        chk_eq("t2_active_start", int'(Frame_Active), 1);
        shift_bits("t2", 16);
        chk_eq("t2_active_cycles", act_cnt - a0, last_rise_cyc - fall_cyc);
        chk_eq("t2_active_end", int'(Frame_Active), 0);
        chk_eq("t2_done_cnt", done_cnt - d0, 1);

        // 3: abort after 3 shifts with new buttons
        d0 = done_cnt;
        latch_frame(12'h010, 2'b00, 0);
        shift_bits("t3a", 3);
        latch_frame(12'h001, 2'b00, 0);
        shift_bits("t3b", 2);
        chk_eq("t3_no_done", done_cnt - d0, 0);
        shift_bits("t3c", 6);
        chk_eq("t3_done_cnt", done_cnt - d0, 1);

        // 4: shifts during latch, extra shifts after DONE
        d0 = done_cnt;
        latch_frame(12'h1A5, 2'b00, 3);
        shift_bits("t4", 8);
        for (int i = 0; i < 20; i++) begin
            pulse_shift(6, 6);
            chk_eq("t4_done_data", int'(Data), 0);
        end
        chk_eq("t4_done_cnt", done_cnt - d0, 1);

        // 5: mode flip mid-frame, then SNES frame
        d0 = done_cnt;
        latch_frame(12'h0F0, 2'b00, 0);
        shift_bits("t5a", 4);
        Mode = 2'b10;
        shift_bits("t5b", 4);
        chk_eq("t5_done_cnt", done_cnt - d0, 1);
        chk_eq("t5_active", int'(Frame_Active), 0);
        chk_eq("t5_data_low", int'(Data), 0);
        latch_frame(12'h5A5, 2'b10, 0);
        shift_bits("t5c", 16);
        chk_eq("t5_done_cnt2", done_cnt - d0, 2);

        // 6: reset mid SNES frame
        d0 = done_cnt;
        latch_frame(12'hA5A, 2'b10, 0);
        shift_bits("t6a", 9);
        chk_eq("t6_active_pre", int'(Frame_Active), 1);
        Reset = 1'b1;
        #1;
        chk_eq("t6_rst_data", int'(Data), 1);
        chk_eq("t6_rst_active", int'(Frame_Active), 0);
        wait_cyc(2);
        Reset = 1'b0;
        exp_q.delete();
        wait_cyc(3);
        chk_eq("t6_idle_data", int'(Data), 1);
        latch_frame(12'hA5A, 2'b10, 0);
        shift_bits("t6b", 16);
        chk_eq("t6_done_cnt", done_cnt - d0, 1);
        chk_eq("t6_data_after", int'(Data), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
